// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: decodes PS/2 scan-code bytes into a 4-bit key state vector.
// Recognises F0 (break) and E0 (extended) prefixes, ignores extended keys,
// and drops a half-received sequence after TIMEOUT_CYC idle cycles.
// Optional build macro PS2_TOGGLE_EN: each make of a mapped key toggles its
// bit instead of following the held level.
module ps2_key_ctrl #(
  parameter logic [7:0] KEY0        = 8'h1C,
  parameter logic [7:0] KEY1        = 8'h1B,
  parameter logic [7:0] KEY2        = 8'h23,
  parameter logic [7:0] KEY3        = 8'h2B,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data_out,
  input  logic       pulso_done,
  output logic [3:0] sensores,
  output logic       key_event,
  output logic [7:0] last_code,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [3:0]    match;
  logic [3:0]    sel;
  logic [3:0]    mk_sens;
  logic [3:0]    bk_sens;
`ifdef PS2_TOGGLE_EN
  logic [3:0]    held;
`endif

  // Map the byte to a one-hot key select; duplicates resolve to the lowest bit
  always_comb begin
    match   = {ps2_data_out == KEY3, ps2_data_out == KEY2,
               ps2_data_out == KEY1, ps2_data_out == KEY0};
    sel     = match & (~match + 4'd1);
`ifdef PS2_TOGGLE_EN
    // A key already held (typematic repeat) does not toggle again
    mk_sens = sensores ^ (sel & ~held);
    bk_sens = sensores;
`else
    mk_sens = sensores | sel;
    bk_sens = sensores & ~sel;
`endif
  end

  // Prefix FSM, timeout counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      sensores  <= 4'h0;
      last_code <= 8'h00;
      key_event <= 1'b0;
      err       <= 1'b0;
`ifdef PS2_TOGGLE_EN
      held      <= 4'h0;
`endif
    end else begin
      key_event <= 1'b0;
      err       <= 1'b0;
      if (pulso_done) begin
        // A byte always wins over a coincident timeout
        tmo_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (ps2_data_out == BRK_CODE)      state <= BRK;
            else if (ps2_data_out == EXT_CODE) state <= EXT;
            else begin
              if (mk_sens != sensores) begin
                sensores  <= mk_sens;
                key_event <= 1'b1;
                last_code <= ps2_data_out;
              end
`ifdef PS2_TOGGLE_EN
              held <= held | sel;
`endif
            end
          end
          BRK: begin
            if (ps2_data_out == BRK_CODE) err <= 1'b1;
            else if (ps2_data_out == EXT_CODE) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              if (bk_sens != sensores) begin
                sensores  <= bk_sens;
                key_event <= 1'b1;
                last_code <= ps2_data_out;
              end
`ifdef PS2_TOGGLE_EN
              held <= held & ~sel;
`endif
              state <= IDLE;
            end
          end
          EXT:     state <= (ps2_data_out == BRK_CODE) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state   <= IDLE;
          err     <= 1'b1;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: expected key_event/err pulses are queued
// with their due cycle; a negedge monitor pops and compares every pulse.
module tb_ps2_key_ctrl;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ps2_data_out = 8'h00;
  logic       pulso_done = 1'b0;
  logic [3:0] sensores;
  logic       key_event;
  logic [7:0] last_code;
  logic       err;

  ps2_key_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .ps2_data_out(ps2_data_out),
    .pulso_done(pulso_done), .sensores(sensores), .key_event(key_event),
    .last_code(last_code), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [3:0] s;
    logic [7:0] lc;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the head of the queue
  always @(negedge clk) begin
    if (reset && (key_event || err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d key_event=%0b err=%0b sensores=%b last_code=%h, required no pulse",
                 cyc, key_event, err, sensores, last_code);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (err !== e.is_err || key_event !== !e.is_err || sensores !== e.s ||
            last_code !== e.lc || cyc != e.due) begin
          errors++;
          $display("FAIL pulse cyc=%0d err=%0b ev=%0b s=%b lc=%h, required cyc=%0d err=%0b s=%b lc=%h",
                   cyc, err, key_event, sensores, last_code, e.due, e.is_err, e.s, e.lc);
        end
      end
    end
  end

  // Queue an expected pulse due off cycles after the next strobe sample
  task automatic exp(input logic is_err, input logic [3:0] s, input logic [7:0] lc, input int off);
    exp_t e;
    e.is_err = is_err; e.s = s; e.lc = lc; e.due = cyc + 1 + off;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic send(input logic [7:0] b);
    ps2_data_out = b;
    pulso_done = 1'b1;
    @(negedge clk);
    pulso_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sensores"}, 32'(sensores), 32'h0);
    chk({tag, "_last_code"}, 32'(last_code), 32'h0);
    chk({tag, "_key_event"}, 32'(key_event), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    idle(2);
    chk_zero("reset");
    reset = 1'b1;
    idle(2);

`ifdef PS2_TOGGLE_EN
    exp(1'b0, 4'b0001, 8'h1C, 0); send(8'h1C); idle(1);
    send(8'hF0); send(8'h1C); idle(1);
    chk("toggle_after_break", 32'(sensores), 32'h1);
    exp(1'b0, 4'b0000, 8'h1C, 0); send(8'h1C); idle(1);
    // repeat while held is suppressed
    exp(1'b0, 4'b0010, 8'h1B, 0); send(8'h1B); send(8'h1B); send(8'h1B); idle(1);
    chk("toggle_typematic", 32'(sensores), 32'h2);
`else
    // make then break
    exp(1'b0, 4'b0001, 8'h1C, 0); send(8'h1C); idle(1);
    send(8'hF0);
    exp(1'b0, 4'b0000, 8'h1C, 0); send(8'h1C); idle(1);
    // typematic
    exp(1'b0, 4'b0010, 8'h1B, 0); send(8'h1B); send(8'h1B); send(8'h1B); idle(1);
    chk("typematic_sensores", 32'(sensores), 32'h2);
    send(8'hF0); exp(1'b0, 4'b0000, 8'h1B, 0); send(8'h1B); idle(1);
    // extended keys have no effect
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C); idle(2);
    chk("extended_sensores", 32'(sensores), 32'h0);
    // timeout after a break prefix, then a fresh make
    exp(1'b1, 4'b0000, 8'h1B, T); send(8'hF0); idle(T + 2);
    exp(1'b0, 4'b0100, 8'h23, 0); send(8'h23); idle(1);
    // byte arriving on the expiry cycle is processed, timeout discarded
    send(8'hF0); idle(T - 1);
    exp(1'b0, 4'b0000, 8'h23, 0); send(8'h23); idle(T + 2);
    // F0 F0 -> err, still in break; F0 E0 -> err, back to idle
    exp(1'b0, 4'b0001, 8'h1C, 0); send(8'h1C);
    send(8'hF0); exp(1'b1, 4'b0001, 8'h1C, 0); send(8'hF0);
    exp(1'b0, 4'b0000, 8'h1C, 0); send(8'h1C);
    send(8'hF0); exp(1'b1, 4'b0000, 8'h1C, 0); send(8'hE0);
    exp(1'b0, 4'b0001, 8'h1C, 0); send(8'h1C);
    send(8'hF0); exp(1'b0, 4'b0000, 8'h1C, 0); send(8'h1C); idle(1);
    // unmapped bytes ignored
    send(8'h55); send(8'hF0); send(8'h55); idle(2);
    chk("unmapped_sensores", 32'(sensores), 32'h0);
    // reset mid-sequence
    exp(1'b0, 4'b1000, 8'h2B, 0); send(8'h2B); send(8'hF0);
    #2 reset = 1'b0;
    #1 chk_zero("midreset");
    idle(2);
    reset = 1'b1;
    idle(1);
    exp(1'b0, 4'b1000, 8'h2B, 0); send(8'h2B); idle(1);
    chk("post_reset_sensores", 32'(sensores), 32'h8);
    send(8'hF0); exp(1'b0, 4'b0000, 8'h2B, 0); send(8'h2B);
`endif
    idle(4);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter KEY0, 8'h1C, scan code mapped to sensores[0].
REQ-002 Parameter KEY1, 8'h1B, scan code mapped to sensores[1].
REQ-003 Parameter KEY2, 8'h23, scan code mapped to sensores[2].
REQ-004 Parameter KEY3, 8'h2B, scan code mapped to sensores[3].
REQ-005 Parameter TIMEOUT_CYC, 100000, clk cycles allowed between a prefix byte and its following byte.
REQ-006 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 ps2_data_out  input  8  received PS/2 byte from the serial receiver, valid while pulso_done=1.
REQ-009 pulso_done  input  1  one-cycle strobe, one received byte.
REQ-010 sensores  output  4  key state vector for the sensor state machine, bit n = KEYn.
REQ-011 key_event  output  1  one-cycle pulse when sensores changes value.
REQ-012 last_code  output  8  last mapped scan code that changed sensores.
REQ-013 err  output  1  one-cycle pulse on protocol error or timeout.

Function
REQ-014 FSM states SHALL be IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-015 IDLE: byte F0 -> BRK; byte E0 -> EXT; other byte -> make handling, stay IDLE.
REQ-016 BRK: any byte other than F0/E0 -> break handling, -> IDLE; byte F0 -> stay BRK with err pulse; byte E0 -> IDLE with err pulse.
REQ-017 EXT: byte F0 -> EXT_BRK; any other byte -> consumed without effect, -> IDLE.
REQ-018 EXT_BRK: any byte -> consumed without effect, -> IDLE; extended keys SHALL never affect sensores.
REQ-019 Make handling: if byte equals KEYn, the held level SHALL set sensores[n]=1 (see REQ-029 for the toggle build); unmapped bytes SHALL be ignored.
REQ-020 Break handling: if byte equals KEYn, sensores[n] SHALL be cleared (held-level build only); unmapped bytes SHALL be ignored.
REQ-021 Latency: sensores, key_event and last_code SHALL update on the clk edge following the cycle in which pulso_done=1 (one-cycle latency).
REQ-022 Typematic repeat of a held key (repeated make) SHALL leave sensores unchanged and SHALL NOT pulse key_event.
REQ-023 Timeout: a counter SHALL run in BRK, EXT and EXT_BRK and clear on every pulso_done; when it reaches TIMEOUT_CYC-1, the FSM SHALL go to IDLE with an err pulse and no change to sensores.
REQ-024 If pulso_done and timeout expiry occur in the same cycle, the byte SHALL be processed normally and the timeout SHALL be discarded.
REQ-025 Duplicate KEYn parameter values SHALL act on the lowest-indexed bit only.
REQ-026 pulso_done=0 SHALL hold all state except the timeout counter.

Reset
REQ-027 reset=0 SHALL immediately force the state to IDLE, sensores=4'h0, last_code=8'h00, key_event=0, err=0, and timeout counter=0, including in the middle of a sequence.
REQ-028 After reset is released, the first byte SHALL be interpreted from IDLE; a break code whose prefix arrived before reset SHALL be treated as a make code.

Configuration
REQ-029 Macro PS2_TOGGLE_EN: when defined, a make of KEYn SHALL invert sensores[n] (key_event pulses), typematic repeats SHALL be suppressed until the matching break, and breaks SHALL NOT clear bits; when undefined, the held-level behaviour of REQ-019 and REQ-020 SHALL apply.

Verification
REQ-030 Bytes 1C, F0, 1C -> sensores 0001 one cycle after the first strobe, then 0000; key_event pulses twice; last_code=1C.
REQ-031 Bytes 1B, 1B, 1B (typematic) -> sensores=0010, exactly one key_event pulse.
REQ-032 Bytes E0, 1C, E0, F0, 1C -> sensores stays 0000, no key_event, no err.
REQ-033 Byte F0, then no strobe for TIMEOUT_CYC cycles -> err pulse, state IDLE; the next byte 23 -> sensores=0100.
REQ-034 Bytes 2B then F0, with reset asserted before the next byte -> all outputs zero immediately; after release, byte 2B -> sensores=1000.
REQ-035 PS2_TOGGLE_EN defined: bytes 1C, F0, 1C, 1C -> sensores 0001, stays 0001 after the break, then 0000 after the second make.
